capture_counter: RTL and testbench



---
 rtl/capture_fifo.sv | 50 +++++
 rtl/capture_counter.sv | 77 +++++++
 tb/tb_capture_counter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/capture_fifo.sv
// First-word-fall-through FIFO. The head is visible on rdata while the FIFO is non-empty, and rdata is 0 when it is empty.
// A pop while empty is ignored. A push while full succeeds only when a pop happens in the same cycle.
module capture_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; rdata is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/capture_counter.sv
// Prescaled up/down counter with synchronous load. A rising edge on save pushes the current count into the snapshot FIFO.
module capture_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   up,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  input  logic                   save,
  input  logic                   rd,
  output logic [WIDTH-1:0]       count,
  output logic                   tick,
  output logic [WIDTH-1:0]       cap_data,
  output logic                   cap_valid,
  output logic                   cap_full,
  output logic [$clog2(DEPTH):0] cap_level,
  output logic                   cap_ovf
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;
  logic          save_q, save_edge, tick_cond, empty;
  logic [LW-1:0] level;

  assign tick_cond = en & (pre == PW'(DIV - 1));
  assign save_edge = save & ~save_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      count <= '0;
      tick  <= 1'b0;
    end else if (load) begin
      pre   <= '0;
      count <= load_val;
      tick  <= 1'b0;
    end else if (tick_cond) begin
      pre   <= '0;
      count <= up ? count + 1'b1 : count - 1'b1;
      tick  <= 1'b1;
    end else begin
      if (en) pre <= pre + 1'b1;
      tick <= 1'b0;
    end
  end

  // save_q comes out of reset high, so a save held through reset is not treated as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      save_q  <= 1'b1;
      cap_ovf <= 1'b0;
    end else begin
      save_q <= save;
      if (save_edge & cap_full & ~rd) cap_ovf <= 1'b1;
    end
  end

  capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (save_edge),
    .pop   (rd),
    .wdata (count),
    .rdata (cap_data),
    .level (level),
    .full  (cap_full),
    .empty (empty)
  );

  assign cap_level = level;
  assign cap_valid = ~empty;
endmodule

// File: tb/tb_capture_counter.sv
// Directed bench for capture_counter (WIDTH=4, DIV=2, DEPTH=4): counting, load, capture FIFO, overflow, async reset.
module tb_capture_counter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       en = 1'b0, up = 1'b1, load = 1'b0, save = 1'b0, rd = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] count, cap_data;
  logic       tick, cap_valid, cap_full, cap_ovf;
  logic [2:0] cap_level;
  int         tests = 0, failed = 0;

  capture_counter #(.WIDTH(4), .DIV(2), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .save(save), .rd(rd), .count(count), .tick(tick), .cap_data(cap_data),
    .cap_valid(cap_valid), .cap_full(cap_full), .cap_level(cap_level), .cap_ovf(cap_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; save = 1'b0; rd = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_count(input logic [3:0] v);
    int n = 0;
    while (count !== v && n < 100) begin cyc(); n++; end
    if (n >= 100) chk("wait_count_timeout", {28'h0, count}, {28'h0, v});
  endtask

  task automatic capture_at(input logic [3:0] v);
    wait_count(v);
    save = 1'b1; cyc();
    save = 1'b0; cyc();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_count"}, {28'h0, count}, 32'h0);
    chk({tag, "_tick"}, {31'h0, tick}, 32'h0);
    chk({tag, "_data"}, {28'h0, cap_data}, 32'h0);
    chk({tag, "_valid"}, {31'h0, cap_valid}, 32'h0);
    chk({tag, "_full"}, {31'h0, cap_full}, 32'h0);
    chk({tag, "_level"}, {29'h0, cap_level}, 32'h0);
    chk({tag, "_ovf"}, {31'h0, cap_ovf}, 32'h0);
  endtask

  initial begin
    // Reset values
    cyc(2);
    check_outputs_zero("rst");

    // Up count: count advances every second edge, wraps at 32 edges
    do_reset(); en = 1'b1; up = 1'b1;
    cyc(); chk("up_e1_count", {28'h0, count}, 32'h0); chk("up_e1_tick", {31'h0, tick}, 32'h0);
    cyc(); chk("up_e2_count", {28'h0, count}, 32'h1); chk("up_e2_tick", {31'h0, tick}, 32'h1);
    cyc(); chk("up_e3_count", {28'h0, count}, 32'h1); chk("up_e3_tick", {31'h0, tick}, 32'h0);
    cyc(27); chk("up_e30_count", {28'h0, count}, 32'hF);
    cyc(2); chk("up_e32_wrap", {28'h0, count}, 32'h0); chk("up_e32_tick", {31'h0, tick}, 32'h1);

    // Down count and freeze
    do_reset(); en = 1'b1; up = 1'b0;
    cyc(2); chk("dn_first", {28'h0, count}, 32'hF); chk("dn_first_tick", {31'h0, tick}, 32'h1);
    cyc(2); chk("dn_second", {28'h0, count}, 32'hE);
    cyc(); en = 1'b0;              // prescaler now at 1
    cyc(5); chk("frz_count", {28'h0, count}, 32'hE); chk("frz_tick", {31'h0, tick}, 32'h0);
    en = 1'b1;
    cyc(); chk("frz_resume", {28'h0, count}, 32'hD); chk("frz_resume_tick", {31'h0, tick}, 32'h1);

    // Load in a tick cycle
    do_reset(); en = 1'b1; up = 1'b1;
    cyc();                         // prescaler at 1: next edge would tick
    load = 1'b1; load_val = 4'hA;
    cyc(); chk("ld_count", {28'h0, count}, 32'hA); chk("ld_tick", {31'h0, tick}, 32'h0);
    load = 1'b0;
    cyc(); chk("ld_hold", {28'h0, count}, 32'hA);
    cyc(); chk("ld_next", {28'h0, count}, 32'hB); chk("ld_next_tick", {31'h0, tick}, 32'h1);

    // Five captures into a 4-deep FIFO: overflow, then drain in order
    do_reset(); en = 1'b1; up = 1'b1;
    capture_at(4'd1); capture_at(4'd3); capture_at(4'd5); capture_at(4'd7); capture_at(4'd9);
    chk("ovf_level", {29'h0, cap_level}, 32'd4);
    chk("ovf_full", {31'h0, cap_full}, 32'h1);
    chk("ovf_flag", {31'h0, cap_ovf}, 32'h1);
    chk("pop0", {28'h0, cap_data}, 32'd1);
    rd = 1'b1;
    cyc(); chk("pop1", {28'h0, cap_data}, 32'd3);
    cyc(); chk("pop2", {28'h0, cap_data}, 32'd5);
    cyc(); chk("pop3", {28'h0, cap_data}, 32'd7);
    cyc(); chk("drain_valid", {31'h0, cap_valid}, 32'h0); chk("drain_data", {28'h0, cap_data}, 32'h0);
    cyc(); chk("rd_empty_level", {29'h0, cap_level}, 32'h0); chk("rd_empty_ovf", {31'h0, cap_ovf}, 32'h1);
    rd = 1'b0;

    // Full FIFO with simultaneous push and pop, then save held high
    do_reset(); en = 1'b1; up = 1'b1;
    capture_at(4'd1); capture_at(4'd2); capture_at(4'd3); capture_at(4'd4);
    chk("fp_full", {31'h0, cap_full}, 32'h1);
    wait_count(4'd6);
    save = 1'b1; rd = 1'b1;
    cyc(); rd = 1'b0;
    chk("fp_level", {29'h0, cap_level}, 32'd4); chk("fp_ovf", {31'h0, cap_ovf}, 32'h0);
    chk("fp_head", {28'h0, cap_data}, 32'd2);
    cyc(10);                       // save still high: no further edge
    chk("hold_level", {29'h0, cap_level}, 32'd4); chk("hold_ovf", {31'h0, cap_ovf}, 32'h0);
    save = 1'b0; rd = 1'b1;
    cyc(); chk("fp_pop3", {28'h0, cap_data}, 32'd3);
    cyc(); chk("fp_pop4", {28'h0, cap_data}, 32'd4);
    cyc(); chk("fp_pop6", {28'h0, cap_data}, 32'd6);
    cyc(); chk("fp_empty", {31'h0, cap_valid}, 32'h0);
    rd = 1'b0;

    // Asynchronous reset mid-operation with 3 entries and overflow set
    do_reset(); en = 1'b1; up = 1'b1;
    capture_at(4'd1); capture_at(4'd3); capture_at(4'd5); capture_at(4'd7); capture_at(4'd9);
    rd = 1'b1; cyc(); rd = 1'b0;
    chk("pre_rst_level", {29'h0, cap_level}, 32'd3); chk("pre_rst_ovf", {31'h0, cap_ovf}, 32'h1);
    #2 rst_n = 1'b0; save = 1'b1;
    #1 check_outputs_zero("async");
    cyc(); rst_n = 1'b1;
    cyc(3); chk("held_save_level", {29'h0, cap_level}, 32'd0);
    save = 1'b0; cyc();
    // Rising save and rd on an empty FIFO: push happens, pop ignored
    wait_count(4'd3);
    save = 1'b1; rd = 1'b1;
    cyc(); save = 1'b0; rd = 1'b0;
    chk("empty_pushpop_level", {29'h0, cap_level}, 32'd1);
    chk("empty_pushpop_data", {28'h0, cap_data}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
